nonce_buffer_reader: RTL and testbench
======================================

# nonce_buffer_reader

Consumer end of the nonce-buffer interface: accepts 32-bit winning nonces pushed by the miner's result path, stores them in a small FIFO, and drains them to the host link as a byte stream with a valid/ready handshake. It sits between the miner top's nonce-buffer writer port and the host-side serial transmitter. Overflow is reported, never back-pressured, because the miner cores cannot stall.

## Interface
- `DEPTH`, default 8: FIFO entries, power of two, ≥2.
- `NONCE_W`, default 32: nonce width, multiple of 8.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `wr_valid`  in  1  nonce strobe from miner, single-cycle per nonce.
- `wr_nonce`  in  NONCE_W  nonce, qualified by `wr_valid`.
- `wr_flush`  in  1  new block started; discard queued nonces.
- `rd_ready`  in  1  host link accepts `rd_byte` this cycle.
- `rd_valid`  out  1  `rd_byte` holds a valid byte.
- `rd_byte`  out  8  current byte, MSB-first within a nonce.
- `rd_last`  out  1  `rd_byte` is the final byte of its nonce.
- `ovf_clear`  in  1  clears `overflow`.
- `overflow`  out  1  sticky: at least one nonce dropped.
- `level`  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the nonce held in the serializer.

## Operation
- FIFO push when `wr_valid`. If the FIFO is full and no pop occurs in the same cycle, the nonce is dropped and `overflow` sets.
- If the FIFO is full and a pop occurs in the same cycle, the push is accepted.
- Serializer FSM:
  - IDLE, FIFO non-empty: pop into the shift register, go to SEND, byte index 0.
  - SEND: `rd_valid`=1. `rd_byte` = shift register bits [NONCE_W-1 -: 8].
  - SEND, on `rd_valid && rd_ready`: shift left 8, index+1.
  - SEND, on acceptance of the last byte (index = NONCE_W/8-1): if the FIFO is non-empty, pop and stay in SEND with index 0. Otherwise go to IDLE.
- `rd_last` = SEND && index = NONCE_W/8-1.
- `rd_byte`, `rd_last` and `rd_valid` are held stable while `rd_valid && !rd_ready`.
- `wr_flush`: FIFO pointers and `level` return to 0 next cycle.
  - A nonce already in the serializer finishes transmission; no partial nonces are ever emitted.
  - A `wr_valid` in the same cycle as `wr_flush` is kept: it becomes the sole entry, `level`=1.
- `ovf_clear` clears `overflow`. If a drop and `ovf_clear` coincide, set wins.
- Reset mid-operation: the FSM returns to IDLE and FIFO contents are lost. All outputs take their reset values asynchronously.

## Timing
- Reset values: `rd_valid`=0, `rd_byte`=0, `rd_last`=0, `overflow`=0, `level`=0. FSM in IDLE.
- Push to first byte, empty buffer: `wr_valid` at cycle N, `level`=1 at N+1, `rd_valid`=1 at N+2.
- No same-cycle bypass.
- With `rd_ready` held high, throughput is one byte per cycle. Consecutive nonces are sent back-to-back with no idle cycle.
- All outputs are registered.

## Configuration
- `NONCE_BUF_STATS_EN` defined: adds output `drop_cnt` [15:0].
  - Increments on each dropped nonce and saturates at 16'hFFFF.
  - Cleared by `ovf_clear`. If a drop and `ovf_clear` coincide, the result is 1.
  - Reset value 0.
- `NONCE_BUF_STATS_EN` undefined: the port and counter are absent. All other behaviour is identical.

## Structure
- Shared `bcminer_pkg` holds `nonce_t` (logic [31:0]), `NONCE_BYTES` and the serializer state enum (`NB_IDLE`, `NB_SEND`).
- One sub-module, `nonce_fifo`: a DEPTH-entry register FIFO with push, pop, flush, full, empty and level, using the same asynchronous active-low `rst`.
- Serializer FSM, overflow logic and optional counter live in the top of this block.

## Test plan
- Single push 32'hDEADBEEF, `rd_ready`=1:
  - `rd_valid` rises 2 cycles after the push.
  - Bytes DE, AD, BE, EF on consecutive cycles, `rd_last` only on EF.
  - Then `rd_valid`=0.
- Back-pressure: push 32'h01020304, toggle `rd_ready` 1,0,0,1,1,0,1:
  - Bytes hold stable while stalled.
  - Exactly 01 02 03 04 are accepted, with no duplicates.
- Overflow, DEPTH=8, `rd_ready`=0:
  - 10 pushes: `level` saturates at 7 because one nonce sits in the serializer; the 9th and 10th pushes are dropped.
  - `overflow`=1; with `NONCE_BUF_STATS_EN` defined, `drop_cnt`=2.
  - `ovf_clear` returns both to 0.
- Flush mid-transfer: 3 nonces queued, byte 1 of the first in flight, then `wr_flush` together with a push of 32'hCAFEF00D:
  - The first nonce completes.
  - Next output is CA FE F0 0D.
  - The two other queued nonces never appear.
- Full-with-pop: FIFO full and the serializer pops on the last-byte handshake while `wr_valid` is asserted: the push is accepted and `overflow` stays 0.
- Async reset asserted mid-nonce, between clock edges: `rd_valid` drops immediately and `level`=0. After release, a new push is sent from its first byte.

Source files
------------

// File: rtl/bcminer_pkg.sv
// Shared bcminer types: nonce word, byte count and the nonce-buffer serializer states.
package bcminer_pkg;

  typedef logic [31:0] nonce_t;

  localparam int NONCE_BYTES = $bits(nonce_t) / 8;

  typedef enum logic [0:0] {
    NB_IDLE = 1'b0,
    NB_SEND = 1'b1
  } nb_state_e;

  // Width of a byte index; never zero, even for single-byte nonces.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nonce_buffer_reader_if.sv
// Nonce-buffer bus: miner write side, host byte-stream read side and status.
// drop_cnt exists only when NONCE_BUF_STATS_EN is defined.
interface nonce_buffer_reader_if #(
  parameter int DEPTH   = 8,
  parameter int NONCE_W = 32
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic               wr_valid;
  logic [NONCE_W-1:0] wr_nonce;
  logic               wr_flush;
  logic               rd_ready;
  logic               rd_valid;
  logic [7:0]         rd_byte;
  logic               rd_last;
  logic               ovf_clear;
  logic               overflow;
  logic [LVL_W-1:0]   level;
`ifdef NONCE_BUF_STATS_EN
  logic [15:0]        drop_cnt;
`endif

  modport master (
    output wr_valid, wr_nonce, wr_flush, rd_ready, ovf_clear,
    input  rd_valid, rd_byte, rd_last, overflow, level
`ifdef NONCE_BUF_STATS_EN
    , input drop_cnt
`endif
  );

  modport slave (
    input  wr_valid, wr_nonce, wr_flush, rd_ready, ovf_clear,
    output rd_valid, rd_byte, rd_last, overflow, level
`ifdef NONCE_BUF_STATS_EN
    , output drop_cnt
`endif
  );

endinterface

// File: rtl/nonce_fifo.sv
// Register FIFO for queued nonces with flush; full at DEPTH-1 because the
// serializer's shift register holds the remaining slot of buffer capacity.
module nonce_fifo #(
  parameter  int DEPTH = 8,
  parameter  int W     = 32,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_idx;
  logic [LVL_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == LVL_W'(DEPTH - 1));
  assign empty   = (count == '0);
  assign level   = count;
  assign dout    = mem[rd_ptr];
  assign pop_ok  = pop && !empty && !flush;
  // A push alongside flush always lands, as the sole entry at slot 0.
  assign push_ok = push && (flush || !full || pop_ok);
  assign wr_idx  = flush ? '0 : wr_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? AW'(1) : '0;
      count  <= push ? LVL_W'(1) : '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_idx] <= din;
  end

endmodule

// File: rtl/nonce_buffer_reader.sv
// Nonce buffer consumer: queues miner nonces, streams them MSB-first as bytes.
// Optional NONCE_BUF_STATS_EN adds a saturating dropped-nonce counter (drop_cnt).
module nonce_buffer_reader
  import bcminer_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NONCE_W = $bits(nonce_t)
) (
  input logic                  clk,
  input logic                  rst,
  nonce_buffer_reader_if.slave bus
);
  localparam int              NB       = NONCE_W / 8;
  localparam int              IW       = idx_width(NB);
  localparam int              LVL_W    = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0]   LAST_IDX = IW'(NB - 1);

  nb_state_e          state_q;
  nb_state_e          state_d;
  logic [NONCE_W-1:0] shreg_q;
  logic [NONCE_W-1:0] fifo_dout;
  logic [IW-1:0]      idx_q;
  logic [LVL_W-1:0]   fifo_level;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic               load;
  logic               shift;
  logic               drop;
  logic               overflow_q;

  nonce_fifo #(
    .DEPTH (DEPTH),
    .W     (NONCE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.wr_valid),
    .din   (bus.wr_nonce),
    .pop   (pop),
    .flush (bus.wr_flush),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= NB_IDLE;
    else      state_q <= state_d;
  end

  // Entries being discarded by a flush are never loaded into the serializer.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      NB_IDLE: begin
        if (!fifo_empty && !bus.wr_flush) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_d = NB_SEND;
        end
      end
      NB_SEND: begin
        if (bus.rd_ready) begin
          if (idx_q == LAST_IDX) begin
            if (!fifo_empty && !bus.wr_flush) begin
              pop  = 1'b1;
              load = 1'b1;
            end else begin
              state_d = NB_IDLE;
            end
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_d = NB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (load) begin
      shreg_q <= fifo_dout;
      idx_q   <= '0;
    end else if (shift) begin
      shreg_q <= shreg_q << 8;
      idx_q   <= idx_q + 1'b1;
    end
  end

  // Drop only when the FIFO stays full through this cycle; flush makes room.
  assign drop = bus.wr_valid && !bus.wr_flush && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               overflow_q <= 1'b0;
    else if (drop)          overflow_q <= 1'b1;
    else if (bus.ovf_clear) overflow_q <= 1'b0;
  end

`ifdef NONCE_BUF_STATS_EN
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                               drop_cnt_q <= '0;
    else if (bus.ovf_clear)                 drop_cnt_q <= drop ? 16'd1 : 16'd0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

  assign bus.rd_valid = (state_q == NB_SEND);
  assign bus.rd_byte  = shreg_q[NONCE_W-1 -: 8];
  assign bus.rd_last  = (state_q == NB_SEND) && (idx_q == LAST_IDX);
  assign bus.level    = fifo_level;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_nonce_buffer_reader.sv
// Self-checking bench for nonce_buffer_reader: queue-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_nonce_buffer_reader;
  localparam int DEPTH   = 8;
  localparam int NONCE_W = 32;
  localparam int NB      = NONCE_W / 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  nonce_buffer_reader_if #(.DEPTH(DEPTH), .NONCE_W(NONCE_W)) bus ();

  nonce_buffer_reader #(.DEPTH(DEPTH), .NONCE_W(NONCE_W)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffered nonces in a queue plus the nonce on the wire.
  logic [31:0] m_q[$];
  logic [31:0] m_cur   = '0;
  bit          m_busy  = 1'b0;
  int          m_sent  = 0;
  bit          m_ovf   = 1'b0;
  int          m_drops = 0;

  always @(posedge clk or negedge rst_n) begin
    bit          fin;
    bit          can_load;
    bit          drop;
    logic [31:0] nxt;
    if (!rst_n) begin
      m_q.delete();
      m_busy  = 1'b0;
      m_sent  = 0;
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      nxt      = '0;
      fin      = m_busy && bus.rd_ready && (m_sent == NB - 1);
      can_load = (!m_busy || fin) && (m_q.size() > 0) && !bus.wr_flush;
      drop     = bus.wr_valid && !bus.wr_flush && (m_q.size() == DEPTH - 1) && !can_load;
      if (can_load) nxt = m_q.pop_front();
      if (bus.wr_flush) m_q.delete();
      if (bus.wr_valid && !drop) m_q.push_back(bus.wr_nonce);
      if (can_load) begin
        m_cur  = nxt;
        m_busy = 1'b1;
        m_sent = 0;
      end else if (fin) begin
        m_busy = 1'b0;
      end else if (m_busy && bus.rd_ready) begin
        m_sent++;
      end
      if (drop)               m_ovf = 1'b1;
      else if (bus.ovf_clear) m_ovf = 1'b0;
      if (bus.ovf_clear)                 m_drops = drop ? 1 : 0;
      else if (drop && m_drops < 65535)  m_drops++;
    end
  end

  logic [7:0] acc_q[$];

  always @(negedge clk) begin
    chk("rd_valid", 32'(bus.rd_valid), 32'(m_busy));
    chk("rd_last", 32'(bus.rd_last), 32'(m_busy && (m_sent == NB - 1)));
    if (m_busy) chk("rd_byte", 32'(bus.rd_byte), 32'(8'(m_cur >> (8 * (NB - 1 - m_sent)))));
    chk("level", 32'(bus.level), 32'(m_q.size()));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef NONCE_BUF_STATS_EN
    chk("drop_cnt", 32'(bus.drop_cnt), 32'(m_drops));
`endif
    if (bus.rd_valid && bus.rd_ready) acc_q.push_back(bus.rd_byte);
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic push(input logic [31:0] n);
    bus.wr_valid = 1'b1;
    bus.wr_nonce = n;
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while ((bus.rd_valid || bus.level != 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n >= max_cyc), 32'd0);
  endtask

  task automatic chk_stream(input string name, input logic [7:0] exp[$]);
    chk({name, "_count"}, 32'(acc_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < acc_q.size(); i++)
      chk(name, 32'(acc_q[i]), 32'(exp[i]));
  endtask

  initial begin
    int max_lvl;
    logic [7:0] exp_b[$];
    bus.wr_valid  = 1'b0;
    bus.wr_nonce  = '0;
    bus.wr_flush  = 1'b0;
    bus.rd_ready  = 1'b0;
    bus.ovf_clear = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("reset_rd_byte", 32'(bus.rd_byte), 32'd0);
    chk("reset_rd_last", 32'(bus.rd_last), 32'd0);
    chk("reset_overflow", 32'(bus.overflow), 32'd0);
    chk("reset_level", 32'(bus.level), 32'd0);
`ifdef NONCE_BUF_STATS_EN
    chk("reset_drop_cnt", 32'(bus.drop_cnt), 32'd0);
`endif
    step();
    rst_n = 1'b1;
    step();

    // Single nonce, host always ready: latency and byte order.
    bus.rd_ready = 1'b1;
    push(32'hDEADBEEF);
    @(negedge clk);
    chk("t1_level_n1", 32'(bus.level), 32'd1);
    chk("t1_valid_n1", 32'(bus.rd_valid), 32'd0);
    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_valid", 32'(bus.rd_valid), 32'd1);
      chk("t1_byte", 32'(bus.rd_byte), 32'(exp_b[i]));
      chk("t1_last", 32'(bus.rd_last), 32'(i == 3));
    end
    @(negedge clk);
    chk("t1_valid_after", 32'(bus.rd_valid), 32'd0);
    step();

    // Back-pressure pattern 1,0,0,1,1,0,1.
    bus.rd_ready = 1'b0;
    acc_q.delete();
    push(32'h01020304);
    step();
    foreach (exp_b[i]) ;
    begin
      bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};
      for (int i = 0; i < 7; i++) begin
        bus.rd_ready = pat[i];
        step();
      end
    end
    bus.rd_ready = 1'b0;
    @(negedge clk);
    chk_stream("t2_bytes", '{8'h01, 8'h02, 8'h03, 8'h04});
    chk("t2_idle", 32'(bus.rd_valid), 32'd0);
    step();

    // Overflow with host stalled.
    acc_q.delete();
    max_lvl = 0;
    for (int i = 0; i < 10; i++) begin
      push(32'h1000_0000 + 32'(i));
      if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
    end
    chk("t3_level", 32'(bus.level), 32'd7);
    chk("t3_max_level", 32'(max_lvl), 32'd7);
    chk("t3_overflow", 32'(bus.overflow), 32'd1);
`ifdef NONCE_BUF_STATS_EN
    chk("t3_drop_cnt", 32'(bus.drop_cnt), 32'd2);
`endif
    bus.ovf_clear = 1'b1;
    step();
    bus.ovf_clear = 1'b0;
    chk("t3_overflow_clr", 32'(bus.overflow), 32'd0);
`ifdef NONCE_BUF_STATS_EN
    chk("t3_drop_cnt_clr", 32'(bus.drop_cnt), 32'd0);
`endif
    bus.rd_ready = 1'b1;
    wait_idle(100);
    chk("t3_count", 32'(acc_q.size()), 32'd32);
    for (int i = 0; i < 8 && acc_q.size() >= 4 * (i + 1); i++)
      chk("t3_nonce", {acc_q[4*i], acc_q[4*i+1], acc_q[4*i+2], acc_q[4*i+3]},
          32'h1000_0000 + 32'(i));
    bus.rd_ready = 1'b0;
    step();

    // Flush while byte 1 of the first nonce is on the wire.
    acc_q.delete();
    push(32'h11111111);
    push(32'h22222222);
    push(32'h33333333);
    bus.rd_ready = 1'b1;
    step();
    bus.wr_flush = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_nonce = 32'hCAFEF00D;
    step();
    bus.wr_flush = 1'b0;
    bus.wr_valid = 1'b0;
    chk("t4_level", 32'(bus.level), 32'd1);
    wait_idle(50);
    chk_stream("t4_bytes", '{8'h11, 8'h11, 8'h11, 8'h11, 8'hCA, 8'hFE, 8'hF0, 8'h0D});
    bus.rd_ready = 1'b0;
    step();

    // Full FIFO, push on the last-byte handshake.
    for (int i = 0; i < 8; i++) push(32'h5000_0000 + 32'(i));
    chk("t5_level_full", 32'(bus.level), 32'd7);
    bus.rd_ready = 1'b1;
    begin
      int n = 0;
      while (!bus.rd_last && n < 10) begin
        step();
        n++;
      end
      chk("t5_last_timeout", 32'(n >= 10), 32'd0);
    end
    push(32'h5000_0008);
    chk("t5_overflow", 32'(bus.overflow), 32'd0);
    chk("t5_level", 32'(bus.level), 32'd7);

    // Asynchronous reset mid-nonce, between edges.
    step();
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(bus.rd_valid), 32'd0);
    chk("t6_level", 32'(bus.level), 32'd0);
    chk("t6_byte", 32'(bus.rd_byte), 32'd0);
    chk("t6_last", 32'(bus.rd_last), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    acc_q.delete();
    push(32'hA5B6C7D8);
    wait_idle(20);
    chk_stream("t6_bytes", '{8'hA5, 8'hB6, 8'hC7, 8'hD8});

    // Randomized traffic against the model.
    for (int seg = 0; seg < 6; seg++) begin
      int wr_pct;
      int rd_pct;
      wr_pct = (seg % 3 == 0) ? 5 : (seg % 3 == 1) ? 20 : 45;
      rd_pct = (seg % 2 == 0) ? 90 : 50;
      for (int c = 0; c < 500; c++) begin
        bus.wr_valid  = ($urandom_range(99) < wr_pct);
        bus.wr_nonce  = $urandom;
        bus.rd_ready  = ($urandom_range(99) < rd_pct);
        bus.wr_flush  = ($urandom_range(99) < 2);
        bus.ovf_clear = ($urandom_range(99) < 4);
        step();
      end
    end
    bus.wr_valid  = 1'b0;
    bus.wr_flush  = 1'b0;
    bus.ovf_clear = 1'b0;
    bus.rd_ready  = 1'b1;
    wait_idle(DEPTH * NB * 2 + 20);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
